search_arbiter: RTL and testbench

- Shares one binary-search engine (sorted 32x8 RAM plus control/datapath) among N_REQ independent requesters.
- Per search it picks one pending requester round-robin, latches that requester's key, clears the engine, runs it to completion, and returns found/loc to the winner with a one-cycle ack.
- A watchdog bounds every search so a hung engine cannot block the other requesters.
- Sits between the engine instance and client logic such as the switch/HEX front end or other FSMs.

---
 rtl/search_arb_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 25 ++
 rtl/search_arbiter.sv | 117 +++++++++++
 tb/tb_search_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/search_arb_pkg.sv
// Shared state encoding, width defaults and result record for the search arbiter.
package search_arb_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RUN,
    RESP
  } state_t;

  typedef struct packed {
    logic                  found;
    logic                  err;
    logic [ADDR_W_DEF-1:0] loc;
  } result_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping modulo N_REQ.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx
);

  // Scan from the farthest offset down so the nearest pending requester wins last.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      if (req[(int'(ptr) + off) % N_REQ]) begin
        grant                                = '0;
        grant[(int'(ptr) + off) % N_REQ]     = 1'b1;
        grant_idx                            = IDX_W'((int'(ptr) + off) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/search_arbiter.sv
// Time-shares one binary-search engine among N_REQ requesters; a watchdog turns a
// stuck engine into an error response so the other requesters keep being served.
module search_arbiter
  import search_arb_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] key,
  output logic [N_REQ-1:0]        ack,
  output logic                    rsp_found,
  output logic [ADDR_W-1:0]       rsp_loc,
  output logic                    rsp_err,
  output logic                    busy,
  output logic                    eng_clear,
  output logic                    eng_start,
  output logic [DATA_W-1:0]       eng_A,
  input  logic                    eng_done,
  input  logic                    eng_found,
  input  logic [ADDR_W-1:0]       eng_loc
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int WD_W  = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   gnt_idx;
  logic [DATA_W-1:0]  key_lat;
  logic [WD_W-1:0]    wdog;
  logic [N_REQ-1:0]   pick;
  logic [IDX_W-1:0]   pick_idx;
  logic [N_REQ-1:0]   gnt_onehot;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req       (req),
    .ptr       (rr_ptr),
    .grant     (pick),
    .grant_idx (pick_idx)
  );

  assign gnt_onehot = N_REQ'(1) << gnt_idx;
  assign busy       = (state != IDLE);

  // The engine is held in reset both by our own reset and for the one CLEAR cycle.
  assign eng_clear  = reset | (state == CLEAR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      gnt_idx   <= '0;
      key_lat   <= '0;
      wdog      <= '0;
      ack       <= '0;
      rsp_found <= 1'b0;
      rsp_loc   <= '0;
      rsp_err   <= 1'b0;
      eng_start <= 1'b0;
      eng_A     <= '0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (|pick) begin
            key_lat <= key[pick_idx*DATA_W +: DATA_W];
            gnt_idx <= pick_idx;
            state   <= CLEAR;
          end
        end
        CLEAR: begin
          eng_start <= 1'b1;
          eng_A     <= key_lat;
          wdog      <= '0;
          state     <= RUN;
        end
        RUN: begin
          // Saturating so the timeout compare can never be skipped by a wrap.
          if (wdog != WD_MAX)
            wdog <= wdog + 1'b1;
          if (eng_done) begin
            rsp_found <= eng_found;
            rsp_loc   <= eng_found ? eng_loc : '0;
            rsp_err   <= 1'b0;
            ack       <= gnt_onehot;
            eng_start <= 1'b0;
            state     <= RESP;
          end else if (wdog == WD_MAX) begin
            rsp_found <= 1'b0;
            rsp_loc   <= '0;
            rsp_err   <= 1'b1;
            ack       <= gnt_onehot;
            eng_start <= 1'b0;
            state     <= RESP;
          end
        end
        RESP: begin
          rr_ptr <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
          wdog   <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_search_arbiter.sv
// Self-checking bench: behavioural binary-search engine over mem[i]=i, plus a
// round-robin/lookup reference model driving directed and random transactions.
module tb_search_arbiter;
  import search_arb_pkg::*;

  localparam int N  = 2;
  localparam int DW = 8;
  localparam int AW = 5;
  localparam int TO = 8;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*DW-1:0] key;
  logic [N-1:0]    ack;
  logic            rsp_found;
  logic [AW-1:0]   rsp_loc;
  logic            rsp_err;
  logic            busy;
  logic            eng_clear;
  logic            eng_start;
  logic [DW-1:0]   eng_A;
  logic            eng_done;
  logic            eng_found;
  logic [AW-1:0]   eng_loc;

  search_arbiter #(
    .N_REQ   (N),
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .key       (key),
    .ack       (ack),
    .rsp_found (rsp_found),
    .rsp_loc   (rsp_loc),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .eng_clear (eng_clear),
    .eng_start (eng_start),
    .eng_A     (eng_A),
    .eng_done  (eng_done),
    .eng_found (eng_found),
    .eng_loc   (eng_loc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Engine stand-in: sorted RAM searched by bisection after a random latency; can hang.
  logic [7:0] eng_mem [32];
  result_t    eng_res;
  int         eng_cnt;
  int         eng_lat;
  bit         eng_hang;

  assign eng_found = eng_res.found;
  assign eng_loc   = eng_res.loc;

  function automatic result_t engSearch(input logic [7:0] k);
    result_t r;
    int lo, hi, mid;
    r  = '0;
    lo = 0;
    hi = 31;
    while (lo <= hi) begin
      mid = (lo + hi) / 2;
      if (eng_mem[mid] == k) begin
        r.found = 1'b1;
        r.loc   = 5'(mid);
        break;
      end else if (eng_mem[mid] < k) lo = mid + 1;
      else hi = mid - 1;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (eng_clear) begin
      eng_done <= 1'b0;
      eng_res  <= '0;
      eng_cnt  <= 0;
    end else if (eng_start && !eng_done && !eng_hang) begin
      if (eng_cnt >= eng_lat) begin
        eng_done <= 1'b1;
        eng_res  <= engSearch(eng_A);
      end else begin
        eng_cnt <= eng_cnt + 1;
      end
    end
  end

  // Reference model state.
  int         ref_mem [32];
  logic [N-1:0] req_cur;
  logic [7:0] key_cur [N];
  int         model_rr;
  bit         in_resp;

  int assert_cnt;
  int fail_cnt;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    assert_cnt++;
    if (actual != expected) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  function automatic int modelPick(input logic [N-1:0] r, input int rr);
    for (int k = 0; k < N; k++)
      if (r[(rr + k) % N]) return (rr + k) % N;
    return 0;
  endfunction

  function automatic result_t modelLookup(input logic [7:0] k);
    result_t r;
    r = '0;
    for (int i = 0; i < 32; i++)
      if (ref_mem[i] == int'(k)) begin
        r.found = 1'b1;
        r.loc   = 5'(i);
      end
    return r;
  endfunction

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput("ack_idle", ack, 0);
    end
    in_resp = 1'b0;
  endtask

  task automatic driveInputs();
    req = req_cur;
    key = {key_cur[1], key_cur[0]};
  endtask

  // One full transaction: add requests, predict the winner, wait for and check its ack.
  task automatic applyStimulus(input logic [N-1:0] add_mask, input logic [7:0] k0,
                               input logic [7:0] k1, input bit hang, input int new_key);
    int      w, n, clr_n, exp_lat;
    logic [7:0] ek;
    result_t exp_r;
    if (add_mask[0]) begin req_cur[0] = 1'b1; key_cur[0] = k0; end
    if (add_mask[1]) begin req_cur[1] = 1'b1; key_cur[1] = k1; end
    if (req_cur == '0) begin
      idleCycles(1);
      return;
    end
    w  = modelPick(req_cur, model_rr);
    ek = key_cur[w];
    if (hang) begin
      exp_r     = '0;
      exp_r.err = 1'b1;
    end else begin
      exp_r = modelLookup(ek);
    end
    eng_hang = hang;
    eng_lat  = $urandom_range(0, 4);
    driveInputs();
    clr_n   = in_resp ? 2 : 1;
    exp_lat = clr_n + 1 + TO;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == clr_n) checkOutput("eng_clear_pulse", eng_clear, 1);
      if (n == clr_n + 1) begin
        checkOutput("eng_clear_low", eng_clear, 0);
        checkOutput("eng_start_run", eng_start, 1);
        checkOutput("eng_A_key", eng_A, ek);
      end
      if (n == 2 && new_key >= 0) begin
        key_cur[0] = 8'(new_key);
        key_cur[1] = 8'(new_key);
        driveInputs();
      end
    end while (ack == '0 && n < 40);
    checkOutput("ack_in_time", (n < 40) ? 1 : 0, 1);
    checkOutput("ack", ack, 1 << w);
    checkOutput("rsp_found", rsp_found, exp_r.found);
    checkOutput("rsp_loc", rsp_loc, exp_r.loc);
    checkOutput("rsp_err", rsp_err, exp_r.err);
    checkOutput("busy_resp", busy, 1);
    checkOutput("eng_start_resp", eng_start, 0);
    if (hang) checkOutput("wd_latency", n, exp_lat);
    req_cur[w] = 1'b0;
    driveInputs();
    model_rr = (w + 1) % N;
    in_resp  = 1'b1;
  endtask

  task automatic drainRequests();
    for (int i = 0; i < N && req_cur != '0; i++)
      applyStimulus('0, 8'd0, 8'd0, 1'b0, -1);
  endtask

  initial begin
    int n_run;
    logic [7:0] rk0, rk1;
    for (int i = 0; i < 32; i++) begin
      eng_mem[i] = 8'(i);
      ref_mem[i] = i;
    end
    assert_cnt = 0;
    fail_cnt   = 0;
    req_cur    = '0;
    key_cur[0] = '0;
    key_cur[1] = '0;
    model_rr   = 0;
    in_resp    = 1'b0;
    eng_hang   = 1'b0;
    eng_lat    = 0;
    reset      = 1'b1;
    req        = '0;
    key        = '0;

    repeat (2) @(negedge clk);
    checkOutput("rst_ack", ack, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_found", rsp_found, 0);
    checkOutput("rst_loc", rsp_loc, 0);
    checkOutput("rst_err", rsp_err, 0);
    checkOutput("rst_eng_start", eng_start, 0);
    checkOutput("rst_eng_A", eng_A, 0);
    checkOutput("rst_eng_clear", eng_clear, 1);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("eng_clear_after_rst", eng_clear, 0);

    $display("[TB] contention");
    applyStimulus(2'b11, 8'd5, 8'd200, 1'b0, -1);
    applyStimulus(2'b01, 8'd5, 8'd0, 1'b0, -1);
    applyStimulus(2'b01, 8'd5, 8'd0, 1'b0, -1);
    drainRequests();
    idleCycles(1);

    $display("[TB] single request and hold");
    applyStimulus(2'b01, 8'd19, 8'd0, 1'b0, -1);
    idleCycles(2);
    checkOutput("rsp_hold_loc", rsp_loc, 19);
    checkOutput("rsp_hold_found", rsp_found, 1);

    $display("[TB] key change mid-search");
    applyStimulus(2'b01, 8'd30, 8'd0, 1'b0, 2);

    $display("[TB] watchdog");
    applyStimulus(2'b01, 8'd7, 8'd0, 1'b1, -1);
    applyStimulus(2'b10, 8'd0, 8'd3, 1'b0, -1);
    idleCycles(2);

    $display("[TB] reset mid-run");
    req_cur[0] = 1'b1;
    key_cur[0] = 8'd30;
    eng_hang   = 1'b1;
    driveInputs();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("midrst_eng_clear", eng_clear, 1);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_ack", ack, 0);
    checkOutput("midrst_eng_start", eng_start, 0);
    repeat (2) @(negedge clk);
    checkOutput("midrst_ack_hold", ack, 0);
    req_cur  = '0;
    driveInputs();
    eng_hang = 1'b0;
    reset    = 1'b0;
    model_rr = 0;
    idleCycles(2);
    checkOutput("postrst_busy", busy, 0);
    applyStimulus(2'b10, 8'd0, 8'd0, 1'b0, -1);

    $display("[TB] random");
    for (int it = 0; it < 60; it++) begin
      rk0 = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 31)) : 8'($urandom_range(0, 255));
      rk1 = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 31)) : 8'($urandom_range(0, 255));
      n_run = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : -1;
      applyStimulus(N'($urandom_range(0, 3)), rk0, rk1, ($urandom_range(0, 7) == 0), n_run);
      if (req_cur == '0 && $urandom_range(0, 2) == 0)
        idleCycles(int'($urandom_range(1, 3)));
    end
    drainRequests();

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
